// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Stimulus-and-capture stage for small combinational blocks (1 to 4 inputs).
// Drives every input combination in ascending order, holds each for SETTLE
// cycles, samples the block's output into a truth table, and compares that
// table row by row against a golden table.
//
// Parameters
//   N_IN    number of inputs of the block under test (1..4), K = 2**N_IN rows
//   SETTLE  cycles vec is held before f_in is sampled (1..15)
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start          begin a sweep (level, honoured only when idle)
//   expected[K]    golden table, bit i = required f for combination i
//   f_in           output of the block under test
//   vec[N_IN]      combination driven to the block under test
//   busy           high while settling/sampling
//   done           one-cycle pulse when a sweep completes
//   table_out[K]   captured truth table
//   match          last completed sweep had no mismatching rows
//   err_count      mismatching rows in the current/last sweep (0..K)
//   first_err_idx  combination of the first mismatch, 0 if none
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(2**N_IN)-1:0]   expected,
    input  logic                   f_in,
    output logic [N_IN-1:0]        vec,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   table_out,
    output logic                   match,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_err_idx
);

    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state;
    logic [3:0]      settle_cnt;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    // Error count including the row being sampled this cycle; lets match be
    // registered together with done so it is already valid in the done cycle.
    always_comb begin
        mismatch = (f_in != expected[vec]);
        err_next = mismatch ? err_count + 1'b1 : err_count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            settle_cnt    <= '0;
            vec           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            table_out     <= '0;
            match         <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        table_out     <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        match         <= 1'b0;
                        settle_cnt    <= '0;
                        vec           <= '0;
                        busy          <= 1'b1;
                        state         <= S_SETTLE;
                    end
                end

                // Counter stops at SETTLE-1 and clears, so exactly SETTLE
                // cycles are spent here per row.
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                S_SAMPLE: begin
                    table_out[vec] <= f_in;
                    err_count      <= err_next;
                    if (mismatch && (err_count == '0)) begin
                        first_err_idx <= vec;
                    end
                    // Last row: vec stays at K-1, no wrap-around.
                    if (vec == VEC_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        match <= (err_next == '0);
                        state <= S_DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= S_SETTLE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: two instances (SETTLE=1 and
// SETTLE=3, both N_IN=2). Stimulus pushes the expected sweep result and the
// cycle its done pulse is due; a monitor per instance pops and compares on
// every done pulse.
module tb_truth_table_sweeper;

    typedef struct {
        logic [3:0] tbl;
        logic [2:0] err;
        logic [1:0] first;
        logic       m;
        int         done_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b;
    logic [3:0] exp_a, exp_b;
    logic       f_a, f_b;
    logic [1:0] vec_a, vec_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic [3:0] tbl_a, tbl_b;
    logic       match_a, match_b;
    logic [2:0] err_a, err_b;
    logic [1:0] first_a, first_b;

    int mode_a = 0;
    int mode_b = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int e0;

    exp_t sb_a[$];
    exp_t sb_b[$];

    truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a), .f_in(f_a),
        .vec(vec_a), .busy(busy_a), .done(done_a), .table_out(tbl_a),
        .match(match_a), .err_count(err_a), .first_err_idx(first_a)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b), .f_in(f_b),
        .vec(vec_b), .busy(busy_b), .done(done_b), .table_out(tbl_b),
        .match(match_b), .err_count(err_b), .first_err_idx(first_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Functions under test: 0 constant-1, 1 XNOR, 2 AND.
    function automatic logic fmodel(input int mode, input logic [1:0] v);
        case (mode)
            0:       return 1'b1;
            1:       return ~(v[1] ^ v[0]);
            2:       return v[1] & v[0];
            default: return 1'b0;
        endcase
    endfunction

    always_comb f_a = fmodel(mode_a, vec_a);
    always_comb f_b = fmodel(mode_b, vec_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Issue a single-cycle start at the current negedge and push the expected
    // result; returns at the negedge right after the accepting edge E0.
    task automatic launch(input bit sel, input int mode, input logic [3:0] golden,
                          input logic [3:0] tbl, input logic [2:0] err,
                          input logic [1:0] first, input logic m, output int e0_o);
        exp_t e;
        e0_o = cyc + 1;
        e.tbl = tbl; e.err = err; e.first = first; e.m = m;
        if (sel == 1'b0) begin
            mode_a = mode; exp_a = golden; start_a = 1'b1;
            e.done_cyc = e0_o + 4 * 2;
            sb_a.push_back(e);
        end else begin
            mode_b = mode; exp_b = golden; start_b = 1'b1;
            e.done_cyc = e0_o + 4 * 4;
            sb_b.push_back(e);
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (done_a === 1'b1) begin
            if (sb_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = sb_a.pop_front();
                chk("a_done_cycle", cyc, e.done_cyc);
                chk("a_table_out", 32'(tbl_a), 32'(e.tbl));
                chk("a_err_count", 32'(err_a), 32'(e.err));
                chk("a_first_err_idx", 32'(first_a), 32'(e.first));
                chk("a_match", 32'(match_a), 32'(e.m));
                chk("a_busy_in_done", 32'(busy_a), 0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (done_b === 1'b1) begin
            if (sb_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = sb_b.pop_front();
                chk("b_done_cycle", cyc, e.done_cyc);
                chk("b_table_out", 32'(tbl_b), 32'(e.tbl));
                chk("b_err_count", 32'(err_b), 32'(e.err));
                chk("b_first_err_idx", 32'(first_b), 32'(e.first));
                chk("b_match", 32'(match_b), 32'(e.m));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; exp_a = '0; exp_b = '0;

        // Reset, then idle with start low.
        repeat (2) @(negedge clk);
        chk("rst_vec", 32'(vec_a), 0);
        chk("rst_table", 32'(tbl_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_first", 32'(first_a), 0);
        chk("rst_match", 32'(match_a), 0);
        chk("rst_busy_b", 32'(busy_b), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy_a), 0);
            chk("idle_done", 32'(done_a), 0);
            chk("idle_vec", 32'(vec_a), 0);
        end

        // Constant-1, golden all ones.
        launch(1'b0, 0, 4'b1111, 4'b1111, 3'd0, 2'd0, 1'b1, e0);
        for (int j = 0; j < 8; j++) begin
            chk("c1_vec_seq", 32'(vec_a), j / 2);
            chk("c1_busy", 32'(busy_a), 1);
            chk("c1_no_early_done", 32'(done_a), 0);
            @(negedge clk);
        end
        chk("c1_done_high", 32'(done_a), 1);
        chk("c1_busy_low", 32'(busy_a), 0);
        @(negedge clk);
        chk("c1_done_low", 32'(done_a), 0);
        chk("c1_match_hold", 32'(match_a), 1);
        chk("c1_vec_hold", 32'(vec_a), 3);
        repeat (2) @(negedge clk);

        // XNOR against a wrong golden: every row mismatches.
        launch(1'b0, 1, 4'b0110, 4'b1001, 3'd4, 2'd0, 1'b0, e0);
        repeat (10) @(negedge clk);

        // AND with SETTLE=3: single mismatch at row 2.
        launch(1'b1, 2, 4'b1100, 4'b1000, 3'd1, 2'd2, 1'b0, e0);
        repeat (20) @(negedge clk);

        // Reset in the middle of a sweep (sampled at E5).
        mode_a = 1; exp_a = 4'b0110; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_pre_table", 32'(tbl_a), 32'h1);
        chk("mid_pre_err", 32'(err_a), 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_vec", 32'(vec_a), 0);
        chk("mid_busy", 32'(busy_a), 0);
        chk("mid_table", 32'(tbl_a), 0);
        chk("mid_err", 32'(err_a), 0);
        chk("mid_done", 32'(done_a), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("mid_quiet_busy", 32'(busy_a), 0);
        end
        launch(1'b0, 0, 4'b1111, 4'b1111, 3'd0, 2'd0, 1'b1, e0);
        repeat (10) @(negedge clk);

        // Start pulse while busy is ignored.
        launch(1'b0, 2, 4'b1000, 4'b1000, 3'd0, 2'd0, 1'b1, e0);
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_start_no_resweep", 32'(busy_a), 0);

        // Start held high: back-to-back sweeps, results cleared on acceptance.
        mode_a = 1; exp_a = 4'b0110; start_a = 1'b1;
        e0 = cyc + 1;
        e.tbl = 4'b1001; e.err = 3'd4; e.first = 2'd0; e.m = 1'b0;
        e.done_cyc = e0 + 8;
        sb_a.push_back(e);
        e.done_cyc = e0 + 18;
        sb_a.push_back(e);
        repeat (10) @(negedge clk);
        chk("b2b_idle_busy", 32'(busy_a), 0);
        chk("b2b_idle_vec", 32'(vec_a), 3);
        @(negedge clk);
        chk("b2b_restart_vec", 32'(vec_a), 0);
        chk("b2b_restart_busy", 32'(busy_a), 1);
        chk("b2b_cleared_err", 32'(err_a), 0);
        chk("b2b_cleared_table", 32'(tbl_a), 0);
        start_a = 1'b0;
        repeat (12) @(negedge clk);

        chk("sb_a_drained", sb_a.size(), 0);
        chk("sb_b_drained", sb_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
